// File: rtl/pixel_luma_conv.sv
// -----------------------------------------------------------------------------
// pixel_luma_conv
// Colour-to-luma converter with per-frame programmable weights, rounding,
// saturation, output modes (grey / binary / inverted binary / inverted grey)
// and per-frame min/max luma statistics. Three-stage pipeline; syncs are
// delayed by the same three cycles so they stay aligned with the data.
//
// Ports
//   i_clk, i_rst_n           pixel clock, asynchronous active-low reset
//   i_rgbdata[23:0]          pixel: RGB565 in [15:0] (IN_FMT=0) or RGB888
//   i_de, i_hs, i_vs         input syncs; i_vs rising edge marks frame start
//   i_coef_r/g/b, i_thresh,
//   i_mode                   requested config, latched on i_vs rising edge
//   o_grey8b                 8-bit output after mode
//   o_greydata               o_grey8b replicated into RGB565
//   o_de, o_hs, o_vs         syncs delayed by three cycles
//   o_frame_min/max          pre-mode luma min/max of the previous frame
//   o_stat_valid             one-cycle pulse when o_frame_min/max update
// -----------------------------------------------------------------------------
module pixel_luma_conv #(
   parameter int unsigned IN_FMT     = 0,
   parameter int unsigned DEF_COEF_R = 77,
   parameter int unsigned DEF_COEF_G = 150,
   parameter int unsigned DEF_COEF_B = 29,
   parameter int unsigned DEF_THRESH = 128
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [23:0] i_rgbdata,
   input  logic        i_de,
   input  logic        i_hs,
   input  logic        i_vs,
   input  logic [7:0]  i_coef_r,
   input  logic [7:0]  i_coef_g,
   input  logic [7:0]  i_coef_b,
   input  logic [7:0]  i_thresh,
   input  logic [1:0]  i_mode,
   output logic [7:0]  o_grey8b,
   output logic [15:0] o_greydata,
   output logic        o_de,
   output logic        o_hs,
   output logic        o_vs,
   output logic [7:0]  o_frame_min,
   output logic [7:0]  o_frame_max,
   output logic        o_stat_valid
);

   localparam logic [7:0] DEF_CR_C = 8'(DEF_COEF_R);
   localparam logic [7:0] DEF_CG_C = 8'(DEF_COEF_G);
   localparam logic [7:0] DEF_CB_C = 8'(DEF_COEF_B);
   localparam logic [7:0] DEF_TH_C = 8'(DEF_THRESH);

   logic        vs_q_r;
   logic        vs_rise_s;
   logic [7:0]  act_cr_r;
   logic [7:0]  act_cg_r;
   logic [7:0]  act_cb_r;
   logic [7:0]  act_thresh_r;
   logic [1:0]  act_mode_r;
   logic [7:0]  r8_s;
   logic [7:0]  g8_s;
   logic [7:0]  b8_s;
   logic [15:0] prod_r_s;
   logic [15:0] prod_g_s;
   logic [15:0] prod_b_s;
   logic [15:0] prod_r_r;
   logic [15:0] prod_g_r;
   logic [15:0] prod_b_r;
   logic [1:0]  mode_s1_r;
   logic [1:0]  mode_s2_r;
   logic [7:0]  thresh_s1_r;
   logic [7:0]  thresh_s2_r;
   logic [2:0]  sync_s1_r;   // {vs, hs, de}
   logic [2:0]  sync_s2_r;
   logic [17:0] sum_s;
   logic [9:0]  luma_raw_s;
   logic [9:0]  luma_raw_r;
   logic [7:0]  luma_s;
   logic [7:0]  mode_out_s;
   logic        out_vs_rise_s;
   logic [7:0]  run_min_r;
   logic [7:0]  run_max_r;

   assign vs_rise_s = i_vs & ~vs_q_r;

   // Frame-start detect and per-frame capture of the requested configuration.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vs_q_r       <= 1'b0;
         act_cr_r     <= DEF_CR_C;
         act_cg_r     <= DEF_CG_C;
         act_cb_r     <= DEF_CB_C;
         act_thresh_r <= DEF_TH_C;
         act_mode_r   <= 2'd0;
      end else begin
         vs_q_r <= i_vs;
         if (vs_rise_s) begin
            act_cr_r     <= i_coef_r;
            act_cg_r     <= i_coef_g;
            act_cb_r     <= i_coef_b;
            act_thresh_r <= i_thresh;
            act_mode_r   <= i_mode;
         end
      end
   end

   // Channel expansion to 8 bits; RGB565 replicates MSBs so full scale maps to 255.
   always_comb begin
      r8_s = 8'd0;
      g8_s = 8'd0;
      b8_s = 8'd0;
      if (IN_FMT == 32'd1) begin
         r8_s = i_rgbdata[23:16];
         g8_s = i_rgbdata[15:8];
         b8_s = i_rgbdata[7:0];
      end else begin
         r8_s = {i_rgbdata[15:11], i_rgbdata[15:13]};
         g8_s = {i_rgbdata[10:5],  i_rgbdata[10:9]};
         b8_s = {i_rgbdata[4:0],   i_rgbdata[4:2]};
      end
   end

   assign prod_r_s = {8'd0, r8_s} * {8'd0, act_cr_r};
   assign prod_g_s = {8'd0, g8_s} * {8'd0, act_cg_r};
   assign prod_b_s = {8'd0, b8_s} * {8'd0, act_cb_r};

   // Stage 1: weighted products; mode/threshold travel with the pixel.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prod_r_r    <= 16'd0;
         prod_g_r    <= 16'd0;
         prod_b_r    <= 16'd0;
         mode_s1_r   <= 2'd0;
         thresh_s1_r <= 8'd0;
         sync_s1_r   <= 3'd0;
      end else begin
         prod_r_r    <= prod_r_s;
         prod_g_r    <= prod_g_s;
         prod_b_r    <= prod_b_s;
         mode_s1_r   <= act_mode_r;
         thresh_s1_r <= act_thresh_r;
         sync_s1_r   <= {i_vs, i_hs, i_de};
      end
   end

   // Rounded sum; three 16-bit products plus 128 always fit in 18 bits.
   assign sum_s      = {2'b00, prod_r_r} + {2'b00, prod_g_r} + {2'b00, prod_b_r} + 18'd128;
   assign luma_raw_s = 10'(sum_s >> 4'd8);

   // Stage 2: unsaturated luma.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         luma_raw_r  <= 10'd0;
         mode_s2_r   <= 2'd0;
         thresh_s2_r <= 8'd0;
         sync_s2_r   <= 3'd0;
      end else begin
         luma_raw_r  <= luma_raw_s;
         mode_s2_r   <= mode_s1_r;
         thresh_s2_r <= thresh_s1_r;
         sync_s2_r   <= sync_s1_r;
      end
   end

   // Saturation (weights summing above 256) and output mode selection.
   always_comb begin
      luma_s     = (luma_raw_r > 10'd255) ? 8'd255 : luma_raw_r[7:0];
      mode_out_s = luma_s;
      case (mode_s2_r)
         2'd0:    mode_out_s = luma_s;
         2'd1:    mode_out_s = (luma_s >= thresh_s2_r) ? 8'd255 : 8'd0;
         2'd2:    mode_out_s = (luma_s >= thresh_s2_r) ? 8'd0 : 8'd255;
         2'd3:    mode_out_s = 8'd255 - luma_s;
         default: mode_out_s = luma_s;
      endcase
   end

   // Stage 3: registered data and sync outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_grey8b <= 8'd0;
         o_de     <= 1'b0;
         o_hs     <= 1'b0;
         o_vs     <= 1'b0;
      end else begin
         o_grey8b <= mode_out_s;
         o_de     <= sync_s2_r[0];
         o_hs     <= sync_s2_r[1];
         o_vs     <= sync_s2_r[2];
      end
   end

   assign o_greydata = {o_grey8b[7:3], o_grey8b[7:2], o_grey8b[7:3]};

   // Detected one stage early so the stat pulse coincides with the o_vs rise.
   assign out_vs_rise_s = sync_s2_r[2] & ~o_vs;

   // Per-frame statistics on pre-mode luma of pixels leaving with o_de high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_min_r    <= 8'd255;
         run_max_r    <= 8'd0;
         o_frame_min  <= 8'd0;
         o_frame_max  <= 8'd0;
         o_stat_valid <= 1'b0;
      end else if (out_vs_rise_s) begin
         o_frame_min  <= run_min_r;
         o_frame_max  <= run_max_r;
         o_stat_valid <= 1'b1;
         run_min_r    <= sync_s2_r[0] ? luma_s : 8'd255;
         run_max_r    <= sync_s2_r[0] ? luma_s : 8'd0;
      end else begin
         o_stat_valid <= 1'b0;
         if (sync_s2_r[0]) begin
            if (luma_s < run_min_r) begin
               run_min_r <= luma_s;
            end
            if (luma_s > run_max_r) begin
               run_max_r <= luma_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_luma_conv.sv
// -----------------------------------------------------------------------------
// tb_pixel_luma_conv
// Drives an RGB565 instance and an RGB888 instance with the same stimulus and
// compares every output, every cycle, against an arithmetic reference model
// (expected values delayed through a queue), plus directed spot checks.
// -----------------------------------------------------------------------------
module tb_pixel_luma_conv;

   logic        clk;
   logic        rst_n;
   logic [23:0] rgb;
   logic        de, hs, vs;
   logic [7:0]  cr, cg, cb, th;
   logic [1:0]  mode;

   logic [7:0]  o_grey [2];
   logic [15:0] o_gd   [2];
   logic        o_de_w [2];
   logic        o_hs_w [2];
   logic        o_vs_w [2];
   logic [7:0]  o_fmin [2];
   logic [7:0]  o_fmax [2];
   logic        o_stat [2];

   pixel_luma_conv #(.IN_FMT(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rgbdata(rgb), .i_de(de), .i_hs(hs), .i_vs(vs),
      .i_coef_r(cr), .i_coef_g(cg), .i_coef_b(cb), .i_thresh(th), .i_mode(mode),
      .o_grey8b(o_grey[0]), .o_greydata(o_gd[0]), .o_de(o_de_w[0]), .o_hs(o_hs_w[0]),
      .o_vs(o_vs_w[0]), .o_frame_min(o_fmin[0]), .o_frame_max(o_fmax[0]),
      .o_stat_valid(o_stat[0]));

   pixel_luma_conv #(.IN_FMT(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rgbdata(rgb), .i_de(de), .i_hs(hs), .i_vs(vs),
      .i_coef_r(cr), .i_coef_g(cg), .i_coef_b(cb), .i_thresh(th), .i_mode(mode),
      .o_grey8b(o_grey[1]), .o_greydata(o_gd[1]), .o_de(o_de_w[1]), .o_hs(o_hs_w[1]),
      .o_vs(o_vs_w[1]), .o_frame_min(o_fmin[1]), .o_frame_max(o_fmax[1]),
      .o_stat_valid(o_stat[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int l0; int l1; int g0; int g1;
      bit de; bit hs; bit vs;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   m_cr, m_cg, m_cb, m_th, m_mode;
   bit   m_vs_prev, m_ovs_prev;
   int   rmin[2], rmax[2], fmin[2], fmax[2];
   int   pulse_cnt, obs_min, obs_max;

   // Luma as defined: channel expansion, weighted sum, +128 rounding, /256, clamp.
   function automatic int exp_luma(input int fmt, input logic [23:0] px,
                                   input int wr, input int wg, input int wb);
      int r, g, b, s;
      if (fmt == 1) begin
         r = int'(px[23:16]); g = int'(px[15:8]); b = int'(px[7:0]);
      end else begin
         r = int'(px[15:11]) * 8 + int'(px[15:11]) / 4;
         g = int'(px[10:5])  * 4 + int'(px[10:5])  / 16;
         b = int'(px[4:0])   * 8 + int'(px[4:0])   / 4;
      end
      s = (r * wr + g * wg + b * wb + 128) / 256;
      if (s > 255) s = 255;
      return s;
   endfunction

   function automatic int apply_mode(input int l, input int md, input int t);
      case (md)
         0: return l;
         1: return (l >= t) ? 255 : 0;
         2: return (l >= t) ? 0 : 255;
         default: return 255 - l;
      endcase
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_cycle(input exp_t e);
      int lv[2], gv[2], gd;
      bit sv;
      lv[0] = e.l0; lv[1] = e.l1; gv[0] = e.g0; gv[1] = e.g1;
      sv = e.vs && !m_ovs_prev;
      for (int k = 0; k < 2; k++) begin
         if (sv) begin
            fmin[k] = rmin[k]; fmax[k] = rmax[k];
            rmin[k] = e.de ? lv[k] : 255;
            rmax[k] = e.de ? lv[k] : 0;
         end else if (e.de) begin
            if (lv[k] < rmin[k]) rmin[k] = lv[k];
            if (lv[k] > rmax[k]) rmax[k] = lv[k];
         end
      end
      m_ovs_prev = e.vs;
      for (int k = 0; k < 2; k++) begin
         gd = ((gv[k] / 8) << 11) | ((gv[k] / 4) << 5) | (gv[k] / 8);
         chk($sformatf("grey8b[%0d]", k),    int'(o_grey[k]), gv[k]);
         chk($sformatf("greydata[%0d]", k),  int'(o_gd[k]),   gd);
         chk($sformatf("de[%0d]", k),        int'(o_de_w[k]), int'(e.de));
         chk($sformatf("hs[%0d]", k),        int'(o_hs_w[k]), int'(e.hs));
         chk($sformatf("vs[%0d]", k),        int'(o_vs_w[k]), int'(e.vs));
         chk($sformatf("stat_valid[%0d]", k), int'(o_stat[k]), int'(sv));
         chk($sformatf("frame_min[%0d]", k), int'(o_fmin[k]), fmin[k]);
         chk($sformatf("frame_max[%0d]", k), int'(o_fmax[k]), fmax[k]);
      end
      if (o_stat[1]) begin
         pulse_cnt++;
         obs_min = int'(o_fmin[1]);
         obs_max = int'(o_fmax[1]);
      end
   endtask

   // One clock: record expectation for current inputs, advance, check outputs.
   task automatic step();
      exp_t e;
      e.l0 = exp_luma(0, rgb, m_cr, m_cg, m_cb);
      e.l1 = exp_luma(1, rgb, m_cr, m_cg, m_cb);
      e.g0 = apply_mode(e.l0, m_mode, m_th);
      e.g1 = apply_mode(e.l1, m_mode, m_th);
      e.de = de; e.hs = hs; e.vs = vs;
      exp_q.push_back(e);
      if (vs && !m_vs_prev) begin
         m_cr = int'(cr); m_cg = int'(cg); m_cb = int'(cb);
         m_th = int'(th); m_mode = int'(mode);
      end
      m_vs_prev = vs;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cycle(e);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      exp_t z;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_grey[%0d]", k), int'(o_grey[k]), 0);
         chk($sformatf("rst_gd[%0d]", k),   int'(o_gd[k]),   0);
         chk($sformatf("rst_de[%0d]", k),   int'(o_de_w[k]), 0);
         chk($sformatf("rst_hs[%0d]", k),   int'(o_hs_w[k]), 0);
         chk($sformatf("rst_vs[%0d]", k),   int'(o_vs_w[k]), 0);
         chk($sformatf("rst_min[%0d]", k),  int'(o_fmin[k]), 0);
         chk($sformatf("rst_max[%0d]", k),  int'(o_fmax[k]), 0);
         chk($sformatf("rst_stat[%0d]", k), int'(o_stat[k]), 0);
         rmin[k] = 255; rmax[k] = 0; fmin[k] = 0; fmax[k] = 0;
      end
      m_cr = 77; m_cg = 150; m_cb = 29; m_th = 128; m_mode = 0;
      m_vs_prev = 1'b0; m_ovs_prev = 1'b0;
      z = '{default: 0};
      exp_q.delete();
      exp_q.push_back(z);
      exp_q.push_back(z);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic set_cfg(input int r, input int g, input int b, input int t, input int md);
      cr = 8'(r); cg = 8'(g); cb = 8'(b); th = 8'(t); mode = 2'(md);
   endtask

   task automatic vs_pulse();
      vs = 1'b1; hold(1); vs = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; rgb = 24'd0; de = 1'b0; hs = 1'b0; vs = 1'b0;
      set_cfg(77, 150, 29, 128, 0);
      #3;
      do_reset();

      // Default weights, both formats.
      de = 1'b1; rgb = 24'h00FFFF; hold(4);
      chk("tp_565_white", int'(o_grey[0]), 255);
      chk("tp_565_white_gd", int'(o_gd[0]), 16'hFFFF);
      rgb = 24'h000000; hold(4);
      chk("tp_565_black", int'(o_grey[0]), 0);
      rgb = 24'h808080; hold(4);
      chk("tp_888_mid", int'(o_grey[1]), 128);
      rgb = 24'hFF0000; hold(4);
      chk("tp_888_red", int'(o_grey[1]), 77);

      // New weights requested mid-frame only apply after the vs rise; saturation.
      set_cfg(200, 200, 200, 128, 0);
      rgb = 24'hFFFFFF; hold(4);
      chk("tp_old_weights", int'(o_grey[1]), 255);
      vs_pulse(); hold(4);
      chk("tp_saturate", int'(o_grey[1]), 255);

      // Binary modes and deferred mode change.
      set_cfg(255, 0, 0, 100, 1); vs_pulse();
      rgb = 24'h630000; hold(4);
      chk("tp_bin_99", int'(o_grey[1]), 0);
      rgb = 24'h640000; hold(4);
      chk("tp_bin_100", int'(o_grey[1]), 255);
      set_cfg(255, 0, 0, 100, 2);
      rgb = 24'h630000; hold(4);
      chk("tp_mode_deferred", int'(o_grey[1]), 0);
      vs_pulse(); hold(4);
      chk("tp_inv_bin_99", int'(o_grey[1]), 255);
      rgb = 24'h640000; hold(4);
      chk("tp_inv_bin_100", int'(o_grey[1]), 0);
      set_cfg(77, 150, 29, 128, 3); vs_pulse();
      rgb = 24'hFF0000; hold(4);
      chk("tp_inv_grey", int'(o_grey[1]), 178);

      // Frame statistics: 4 pixels then an empty frame.
      set_cfg(255, 0, 0, 128, 0);
      de = 1'b0; rgb = 24'd0; vs_pulse(); hold(4);
      pulse_cnt = 0;
      de = 1'b1;
      rgb = 24'h0A0000; hold(1);
      rgb = 24'hC90000; hold(1);
      rgb = 24'h370000; hold(1);
      rgb = 24'hC90000; hold(1);
      de = 1'b0; rgb = 24'd0; hold(2);
      vs_pulse(); hold(5);
      chk("tp_stat_pulses", pulse_cnt, 1);
      chk("tp_stat_min", obs_min, 10);
      chk("tp_stat_max", obs_max, 200);
      pulse_cnt = 0;
      vs_pulse(); hold(5);
      chk("tp_empty_pulses", pulse_cnt, 1);
      chk("tp_empty_min", obs_min, 255);
      chk("tp_empty_max", obs_max, 0);

      // Randomised traffic with occasional frame starts and config changes.
      for (int i = 0; i < 400; i++) begin
         rgb  = 24'($urandom);
         de   = ($urandom_range(0, 3) != 0);
         hs   = 1'($urandom_range(0, 1));
         vs   = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 7) == 0) begin
            set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 3));
         end
         step();
      end

      // Reset mid-frame with pixels in flight.
      vs = 1'b0; de = 1'b1; hs = 1'b1; rgb = 24'h123456; hold(3);
      set_cfg(10, 10, 10, 128, 0);
      do_reset();
      vs = 1'b1; de = 1'b1; hs = 1'b0; rgb = 24'hFF0000; hold(1);
      vs = 1'b0; hold(2);
      chk("tp_post_reset_default", int'(o_grey[1]), 77);
      hold(4);

      for (int i = 0; i < 150; i++) begin
         rgb = 24'($urandom);
         de  = ($urandom_range(0, 3) != 0);
         hs  = 1'($urandom_range(0, 1));
         vs  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 5) == 0) begin
            set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 3));
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
